fp_add_arbiter: RTL
===================

Name: fp_add_arbiter

Overview:
- Shares one combinational FP32 adder among NUM_REQ requesters using round-robin arbitration.
- The adder is instantiated outside this block. This block drives its operand inputs from registers and captures its sum output.
- Two-stage pipeline: operand stage (OP), then response stage (RS).
- Results return with the requester ID under a valid/ready handshake with backpressure.
- Sits between the row-accumulate producers and the shared adder in the decompress/accumulate datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, response ID width; must be at least clog2(NUM_REQ).
- DATA_W, 32, operand width, IEEE-754 single precision.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*DATA_W  operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot or zero; request accepted.
- adder_a  out  DATA_W  registered operand A to the shared adder.
- adder_b  out  DATA_W  registered operand B to the shared adder.
- adder_sum  in  DATA_W  combinational sum of adder_a and adder_b.
- resp_valid  out  1  result valid.
- resp_data  out  DATA_W  registered sum.
- resp_id  out  ID_W  index of the requester that owns resp_data.
- resp_ready  in  1  consumer accepts the result.
- busy  out  1  high while OP or RS holds data.

Behaviour:
- Reset (rst=0, asynchronous):
  - OP and RS valid flags cleared.
  - adder_a, adder_b and resp_data set to 0; resp_id set to 0; resp_valid=0; busy=0.
  - Round-robin pointer set to 0.
  - In-flight operations are discarded. No response is produced for them after reset releases.
- Stage advance conditions:
  - rs_free = !rs_valid || resp_ready.
  - op_free = !op_valid || rs_free.
- Grant (combinational):
  - Search from the pointer upward with wrap-around; the first asserted req_valid[i] wins.
  - req_ready[i] = win[i] && op_free.
  - At most one req_ready bit is high per cycle.
  - req_ready may depend on req_valid.
  - A requester must hold valid, a and b stable until it sees ready.
- Accept on an edge where req_valid[i] && req_ready[i]:
  - adder_a <= a_i, adder_b <= b_i, op_id <= i, op_valid <= 1.
  - Pointer <= (i+1) mod NUM_REQ.
  - The pointer is unchanged when nothing is accepted.
- OP to RS move: on an edge where op_valid && rs_free:
  - resp_data <= adder_sum, resp_id <= op_id, rs_valid <= 1.
  - op_valid is cleared unless a new accept occurs on the same edge.
- Response:
  - resp_valid = rs_valid.
  - The result is consumed on resp_valid && resp_ready.
  - rs_valid clears unless OP moves in on the same edge.
- Latency: accept at edge E0 gives resp_valid high after edge E1, i.e. one cycle after the accept edge, with no stall.
- Throughput: one result per cycle when resp_ready is held high.
- Stall:
  - RS full and resp_ready=0: RS holds.
  - OP also full: OP holds, adder_a and adder_b stable, all req_ready=0.
- Simultaneous events: accept, move and consume on the same edge are all legal. No data is lost or duplicated.
- busy = op_valid || rs_valid.
- The adder's internal behaviour (NaN, denormals) is outside this block's scope; the sum passes through bit-exact.

Test Plan:
- Single request:
  - Stimulus: reset, then req_valid=0001, a0=0x40000000 (2.0), b0=0x00000000.
  - Required: req_ready=0001 for one cycle; next cycle resp_valid=1, resp_data=0x40000000, resp_id=0.
- Single request, nonzero B:
  - Stimulus: requester 2, a=0x40000000 (2.0), b=0x3F000000 (0.5).
  - Required: resp_data=0x40200000 (2.5), resp_id=2, latency 1 cycle after the accept edge.
- Round-robin fairness:
  - Stimulus: all four requesters valid continuously, resp_ready=1, each adding 0x3F800000 + 0x3F800000.
  - Required: grants 0,1,2,3,0,... one per cycle; each resp_data=0x40000000; resp_id sequence matches the grants.
- Backpressure:
  - Stimulus: resp_ready=0 with two requests issued.
  - Required: first result held in RS, second held in OP; req_ready=0; adder_a and adder_b stable.
  - Then resp_ready=1: both results delivered in order on consecutive cycles with none lost.
- Reset mid-operation:
  - Stimulus: assert rst low while OP and RS are both valid.
  - Required: resp_valid and busy drop immediately (asynchronously); after release no stale response appears; first grant goes to the lowest valid index from pointer 0.
- Sparse wrap-around:
  - Stimulus: only requesters 3 and 1 valid, pointer at 2.
  - Required: grant order 3, 1, 3, 1.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one external combinational FP32 adder.
// The operand stage (OP) registers the winning requester's operands onto the
// adder inputs. The response stage (RS) captures the adder sum and presents it
// with the owning requester's ID under a valid/ready handshake. Either stage
// may stall under backpressure without losing or duplicating data.

module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         adder_a,
  output logic [DATA_W-1:0]         adder_b,
  input  logic [DATA_W-1:0]         adder_sum,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      resp_ready,
  output logic                      busy
);

  // Result of a round-robin search: whether anyone is requesting, and who.
  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // Scan from the pointer upward with wrap-around; the first valid requester wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                    input logic [ID_W-1:0]    ptr);
    pick_t res;
    int    cand;
    logic  hit;
    res.found = 1'b0;
    res.idx   = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand      = (int'(ptr) + k) % NUM_REQ;
      hit       = !res.found && valid[cand];
      res.idx   = hit ? ID_W'(cand) : res.idx;
      res.found = res.found | hit;
    end
    return res;
  endfunction

  // Pipeline state
  logic              op_valid_r;
  logic              rs_valid_r;
  logic              busy_r;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   op_id_r;
  logic [ID_W-1:0]   resp_id_r;
  logic [DATA_W-1:0] op_a_r;
  logic [DATA_W-1:0] op_b_r;
  logic [DATA_W-1:0] resp_data_r;

  // Combinational control
  pick_t             pick_s;
  logic              rs_free_s;
  logic              op_free_s;
  logic              accept_s;
  logic              move_s;
  logic              consume_s;
  logic              op_valid_nxt_s;
  logic              rs_valid_nxt_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [DATA_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_b_s;

  // Stage advance: RS frees when empty or drained this cycle; OP frees when
  // empty or able to move into RS.
  always_comb begin
    rs_free_s = !rs_valid_r || resp_ready;
    op_free_s = !op_valid_r || rs_free_s;
    move_s    = op_valid_r && rs_free_s;
    consume_s = rs_valid_r && resp_ready;
  end

  // Arbitration: grant only when OP can take the operands this cycle.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    pick_s      = rr_pick(req_valid, ptr_r);
    accept_s    = pick_s.found && op_free_s;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_s[i] = accept_s && (pick_s.idx == ID_W'(i));
    end
  end

  // Pointer advances to the slot just past the winner, wrapping at NUM_REQ.
  always_comb begin
    next_ptr_s = {ID_W{1'b0}};
    if (pick_s.idx == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = pick_s.idx + ID_W'(1'b1);
    end
  end

  // Operand mux: AND-OR select of the winner's packed operands.
  always_comb begin
    sel_a_s = {DATA_W{1'b0}};
    sel_b_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s = sel_a_s | ((pick_s.idx == ID_W'(i)) ? req_a[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
      sel_b_s = sel_b_s | ((pick_s.idx == ID_W'(i)) ? req_b[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
    end
  end

  // Next-state of the stage valid flags; a same-edge refill wins over a drain.
  always_comb begin
    op_valid_nxt_s = op_valid_r;
    rs_valid_nxt_s = rs_valid_r;
    if (accept_s) begin
      op_valid_nxt_s = 1'b1;
    end else if (move_s) begin
      op_valid_nxt_s = 1'b0;
    end else begin
      op_valid_nxt_s = op_valid_r;
    end
    if (move_s) begin
      rs_valid_nxt_s = 1'b1;
    end else if (consume_s) begin
      rs_valid_nxt_s = 1'b0;
    end else begin
      rs_valid_nxt_s = rs_valid_r;
    end
  end

  // Control registers: stage flags, registered busy and the round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_r <= 1'b0;
      rs_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      ptr_r      <= {ID_W{1'b0}};
    end else begin
      op_valid_r <= op_valid_nxt_s;
      rs_valid_r <= rs_valid_nxt_s;
      busy_r     <= op_valid_nxt_s || rs_valid_nxt_s;
      if (accept_s) begin
        ptr_r <= next_ptr_s;
      end
    end
  end

  // OP data: operands and owner load only on accept, so they stay stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_r  <= {DATA_W{1'b0}};
      op_b_r  <= {DATA_W{1'b0}};
      op_id_r <= {ID_W{1'b0}};
    end else if (accept_s) begin
      op_a_r  <= sel_a_s;
      op_b_r  <= sel_b_s;
      op_id_r <= pick_s.idx;
    end
  end

  // RS data: capture the adder sum and owner as OP moves forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_data_r <= {DATA_W{1'b0}};
      resp_id_r   <= {ID_W{1'b0}};
    end else if (move_s) begin
      resp_data_r <= adder_sum;
      resp_id_r   <= op_id_r;
    end
  end

  assign req_ready  = req_ready_s;
  assign adder_a    = op_a_r;
  assign adder_b    = op_b_r;
  assign resp_valid = rs_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_id    = resp_id_r;
  assign busy       = busy_r;

endmodule
